// File: rtl/m_bus_arb.sv
// Clocked bus arbiter: per-requester pending flags, one-hot grant, minimum tenure, one-cycle turnaround.
// Optional macro ARB_RR_EN selects round-robin winner selection; the default is fixed priority (lowest index wins).
module m_bus_arb #(
    parameter int NREQ    = 3,
    parameter int HOLDMIN = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] REL,
    output logic [NREQ-1:0] PEND,
    output logic [NREQ-1:0] GNT,
    output logic [2:0]      GNTID,
    output logic            BUSY
);

    // state | meaning
    // IDLE  | no owner, waiting for any pending flag
    // OWN   | one requester holds the bus, tenure counting
    // TURN  | dead cycle between owners, arbitration for the next owner
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(HOLDMIN);

    state_t          state, state_nxt;
    logic [3:0]      hold_cnt, hold_cnt_nxt;
    logic            rel_pend, rel_pend_nxt;
    logic [NREQ-1:0] pend_nxt, gnt_nxt, grant_mask;
    logic [2:0]      gntid_nxt, winner;
    logic            win_valid, own_rel;

`ifdef ARB_RR_EN
    int dist, best;

    // Search order starts just past the last owner; GNTID resets to NREQ-1 so the first search starts at 0.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        dist      = 0;
        best      = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            if (PEND[j]) begin
                dist = (j + 2 * NREQ - int'(GNTID) - 1) % NREQ;
                if (dist < best) begin
                    best      = dist;
                    winner    = 3'(j);
                    win_valid = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (PEND[j]) begin
                winner    = 3'(j);
                win_valid = 1'b1;
            end
        end
    end
`endif

    assign own_rel = |(REL & GNT);

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rel_pend_nxt = rel_pend;
        gnt_nxt      = GNT;
        gntid_nxt    = GNTID;
        grant_mask   = '0;
        case (state)
            S_IDLE, S_TURN: begin
                if (win_valid) begin
                    state_nxt    = S_OWN;
                    gnt_nxt      = NREQ'(1) << winner;
                    grant_mask   = NREQ'(1) << winner;
                    gntid_nxt    = winner;
                    hold_cnt_nxt = 4'd1;
                    rel_pend_nxt = 1'b0;
                end else begin
                    state_nxt = S_IDLE;
                    gnt_nxt   = '0;
                end
            end
            S_OWN: begin
                if ((hold_cnt >= HOLD_MAX) && (own_rel || rel_pend)) begin
                    state_nxt    = S_TURN;
                    gnt_nxt      = '0;
                    rel_pend_nxt = 1'b0;
                end else begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt_nxt = hold_cnt + 4'd1;
                    end
                    rel_pend_nxt = rel_pend | own_rel;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase
        // A new request on the grant edge re-arms the flag (set dominates clear).
        pend_nxt = (PEND & ~grant_mask) | REQ;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            hold_cnt <= 4'd0;
            rel_pend <= 1'b0;
            PEND     <= '0;
            GNT      <= '0;
            GNTID    <= 3'(NREQ - 1);
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            rel_pend <= rel_pend_nxt;
            PEND     <= pend_nxt;
            GNT      <= gnt_nxt;
            GNTID    <= gntid_nxt;
        end
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_m_bus_arb.sv
// Self-checking bench for m_bus_arb: directed vector table, grant-order sequence, randomized run vs. a reference model.
module tb_m_bus_arb;

    localparam int NREQ    = 3;
    localparam int HOLDMIN = 2;

    logic            CLK;
    logic            RESET;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] REL;
    logic [NREQ-1:0] PEND;
    logic [NREQ-1:0] GNT;
    logic [2:0]      GNTID;
    logic            BUSY;

    int n_vec = 0;
    int n_err = 0;

    m_bus_arb #(.NREQ(NREQ), .HOLDMIN(HOLDMIN)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .REQ  (REQ),
        .REL  (REL),
        .PEND (PEND),
        .GNT  (GNT),
        .GNTID(GNTID),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: who owns the bus, how long it has owned it, and the pending set.
    bit [2:0] m_pend;
    int       m_owner;
    int       m_ten;
    bit       m_early;
    bit       m_turn;
    int       m_last;

    function automatic int pick(input bit [2:0] p, input int last);
`ifdef ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (((p >> i) & 3'b001) != 3'b000) return i;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (((p >> i) & 3'b001) != 3'b000) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_update(input bit rst, input bit [2:0] req, input bit [2:0] rel);
        int  w;
        bit  orel;
        if (rst) begin
            m_pend  = '0;
            m_owner = -1;
            m_ten   = 0;
            m_early = 0;
            m_turn  = 0;
            m_last  = NREQ - 1;
        end else if (m_owner >= 0) begin
            orel = ((rel >> m_owner) & 3'b001) != 3'b000;
            if (m_ten >= HOLDMIN && (orel || m_early)) begin
                m_owner = -1;
                m_turn  = 1;
            end else begin
                if (orel) m_early = 1;
                m_ten++;
            end
            m_pend = m_pend | req;
        end else begin
            w      = pick(m_pend, m_last);
            m_turn = 0;
            if (w >= 0) begin
                m_pend  = m_pend & ~(3'b001 << w);
                m_owner = w;
                m_last  = w;
                m_ten   = 1;
                m_early = 0;
            end
            m_pend = m_pend | req;
        end
    endtask

    task automatic step(input bit rst, input bit [2:0] req, input bit [2:0] rel);
        RESET = rst;
        REQ   = req;
        REL   = rel;
        @(posedge CLK);
        model_update(rst, req, rel);
        #1;
    endtask

    typedef struct {
        bit       rst;
        bit [2:0] req;
        bit [2:0] rel;
        bit [2:0] pend;
        bit [2:0] gnt;
        bit [2:0] id;
        bit       busy;
    } vec_t;

    vec_t tbl[$];
    int   ord_exp[4];
    int   ord_got[4];

    initial begin
        bit [2:0] e_gnt;
        bit       e_busy;
        bit [2:0] rq, rl;
        int       c;

        RESET = 1'b1;
        REQ   = '0;
        REL   = '0;

        //                rst req     rel     pend    gnt     id      busy
        tbl.push_back('{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0}); // reset
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 3'b001, 3'b000, 3'd2, 1'b0}); // single request
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1}); // early release
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b1}); // turnaround
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 3'b001, 3'b000, 3'd0, 1'b0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 3'b001, 3'b001, 3'd0, 1'b1}); // set-dominant race
        tbl.push_back('{1'b0, 3'b000, 3'b010, 3'b001, 3'b001, 3'd0, 1'b1}); // foreign release
        tbl.push_back('{1'b0, 3'b000, 3'b010, 3'b001, 3'b001, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b001, 3'b001, 3'b000, 3'd0, 1'b1}); // release at HOLDMIN
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 3'd0, 1'b1}); // re-grant of 0
        tbl.push_back('{1'b0, 3'b000, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0});
        tbl.push_back('{1'b0, 3'b111, 3'b000, 3'b111, 3'b000, 3'd0, 1'b0}); // contention
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b110, 3'b001, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b001, 3'b110, 3'b001, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b110, 3'b000, 3'd0, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b100, 3'b010, 3'd1, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b010, 3'b100, 3'b010, 3'd1, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b100, 3'b000, 3'd1, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 3'd2, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b100, 3'b000, 3'b100, 3'd2, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2, 1'b1});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 3'b001, 3'b000, 3'd2, 1'b0}); // reset mid-tenure
        tbl.push_back('{1'b0, 3'b110, 3'b000, 3'b110, 3'b001, 3'd0, 1'b1});
        tbl.push_back('{1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rel);
            n_vec++;
            if ({PEND, GNT, GNTID, BUSY} !== {tbl[i].pend, tbl[i].gnt, tbl[i].id, tbl[i].busy}) begin
                n_err++;
                $display("FAIL table[%0d]: got pend=%b gnt=%b id=%0d busy=%b, want pend=%b gnt=%b id=%0d busy=%b",
                         i, PEND, GNT, GNTID, BUSY, tbl[i].pend, tbl[i].gnt, tbl[i].id, tbl[i].busy);
            end
        end

        // Grant order under contention with a re-request by 0 during tenure of 1.
`ifdef ARB_RR_EN
        ord_exp = '{0, 1, 2, 0};
`else
        ord_exp = '{0, 1, 0, 2};
`endif
        step(1'b1, 3'b000, 3'b000);
        step(1'b0, 3'b111, 3'b000);
        for (int g = 0; g < 4; g++) begin
            c = 0;
            while (GNT == '0 && c < 20) begin
                step(1'b0, 3'b000, 3'b000);
                c++;
            end
            ord_got[g] = int'(GNTID);
            n_vec++;
            if (GNT == '0) begin
                n_err++;
                $display("FAIL order_wait[%0d]: got gnt=%b after %0d cycles, want a grant", g, GNT, c);
            end else if (ord_got[g] != ord_exp[g]) begin
                n_err++;
                $display("FAIL order[%0d]: got owner %0d, want %0d", g, ord_got[g], ord_exp[g]);
            end
            step(1'b0, (g == 1) ? 3'b001 : 3'b000, GNT);
            c = 0;
            while (GNT != '0 && c < 20) begin
                step(1'b0, 3'b000, 3'b000);
                c++;
            end
        end

        // Randomized traffic checked cycle by cycle against the model.
        step(1'b1, 3'b000, 3'b000);
        for (int n = 0; n < 3000; n++) begin
            rq = '0;
            rl = '0;
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 3) == 0) rq = rq | (3'b001 << b);
                if ($urandom_range(0, 9) == 0) rl = rl | (3'b001 << b);
            end
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) rl = rl | (3'b001 << m_owner);
            step($urandom_range(0, 99) == 0, rq, rl);
            e_gnt  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
            e_busy = (m_owner >= 0) || m_turn;
            n_vec++;
            if ({PEND, GNT, GNTID, BUSY} !== {m_pend, e_gnt, 3'(m_last), e_busy}) begin
                n_err++;
                $display("FAIL random[%0d]: got pend=%b gnt=%b id=%0d busy=%b, want pend=%b gnt=%b id=%0d busy=%b",
                         n, PEND, GNT, GNTID, BUSY, m_pend, e_gnt, m_last, e_busy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
